// File: rtl/i2c_reg_seq_if.sv
// Request/response and byte-controller signals of the register sequencer.
// slave: the sequencer side; master: requester plus byte controller.
interface i2c_reg_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [2:0] rsp_err_step;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  m_ready, m_done_tick, m_ack, m_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_step,
    output m_cmd, m_din, m_wr
  );

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output m_ready, m_done_tick, m_ack, m_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_step,
    input  m_cmd, m_din, m_wr
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// Single-byte register read/write sequencer feeding an i2c_master byte
// controller. Expands one request into START/WR/RESTART/RD/STOP commands
// and returns read data plus NACK status with a one-cycle response pulse.
module i2c_reg_seq (
  input  logic clk,
  input  logic rst,
  i2c_reg_seq_if.slave bus
);
  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_RESP} state_t;

  state_t     state, state_nx;
  logic [2:0] step, step_nx;
  logic       rw;
  logic [6:0] dev;
  logic [7:0] reg_addr, wdata, rdata;
  logic       err;
  logic [2:0] err_step;
  logic       byte_done;
  logic [2:0] cmd;
  logic [7:0] din;
  logic       xfer, last, accept;

  // Command list decode: purely from step and latched request fields, so
  // the controller-facing outputs never see a combinational m_* path.
  always_comb begin
    cmd = CMD_STOP;
    din = 8'h00;
    case (step)
      3'd0: cmd = CMD_START;
      3'd1: begin cmd = CMD_WR; din = {dev, 1'b0}; end
      3'd2: begin cmd = CMD_WR; din = reg_addr; end
      3'd3: begin
        if (rw) cmd = CMD_RESTART;
        else begin cmd = CMD_WR; din = wdata; end
      end
      3'd4: if (rw) begin cmd = CMD_WR; din = {dev, 1'b1}; end
      3'd5: if (rw) begin cmd = CMD_RD; din = 8'h01; end
      default: cmd = CMD_STOP;
    endcase
  end

  assign xfer   = (cmd == CMD_WR) || (cmd == CMD_RD);
  assign last   = (cmd == CMD_STOP);
  assign accept = bus.req_valid && bus.req_ready;

  // State and step registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= 3'd0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Next-state, step advance and handshake outputs.
  always_comb begin
    state_nx      = state;
    step_nx       = step;
    bus.req_ready = 1'b0;
    bus.m_wr      = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = bus.m_ready && !rst;
        if (accept) begin
          state_nx = S_ISSUE;
          step_nx  = 3'd0;
        end
      end
      S_ISSUE: begin
        bus.m_wr = 1'b1;
        state_nx = S_GAP;
      end
      // The controller drops ready for one cycle after a strobe; skip it.
      S_GAP: state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.m_ready && (!xfer || byte_done)) begin
          if (last) state_nx = S_RESP;
          else begin
            state_nx = S_ISSUE;
            // A NACKed byte aborts straight to the STOP entry of the list.
            if (err) step_nx = rw ? 3'd6 : 3'd4;
            else     step_nx = step + 3'd1;
          end
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, byte completion tracking, ACK error and read capture.
  // GAP is included so a done_tick arriving early is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw        <= 1'b0;
      dev       <= 7'd0;
      reg_addr  <= 8'h00;
      wdata     <= 8'h00;
      rdata     <= 8'h00;
      err       <= 1'b0;
      err_step  <= 3'd0;
      byte_done <= 1'b0;
    end else if (accept) begin
      rw        <= bus.req_rw;
      dev       <= bus.req_dev;
      reg_addr  <= bus.req_reg;
      wdata     <= bus.req_wdata;
      rdata     <= 8'h00;
      err       <= 1'b0;
      err_step  <= 3'd0;
      byte_done <= 1'b0;
    end else if (state == S_ISSUE) begin
      byte_done <= 1'b0;
    end else if ((state == S_GAP || state == S_WAIT) && bus.m_done_tick) begin
      byte_done <= 1'b1;
      if (cmd == CMD_WR && bus.m_ack) begin
        err      <= 1'b1;
        err_step <= step;
      end
      if (cmd == CMD_RD) rdata <= bus.m_dout;
    end
  end

  assign bus.m_cmd        = cmd;
  assign bus.m_din        = din;
  assign bus.rsp_rdata    = rdata;
  assign bus.rsp_err      = err;
  assign bus.rsp_err_step = err_step;
endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-access sequencer placed directly upstream of the `i2c_master` byte-level controller. It accepts one single-byte register read or write request per transaction. It expands the request into the START / WR / RESTART / RD / STOP command stream on the controller's `cmd`/`din`/`wr_i2c` interface, paced by the controller's `ready`, `done_tick`, `ack` and `dout`. It returns read data and a NACK error status to the requester with a one-cycle response pulse.

## Interface
- Parameters: none. Command encodings are fixed to match the controller: START=3'b000, WR=3'b001, RD=3'b010, STOP=3'b011, RESTART=3'b100.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` is high at a rising edge.
- `req_rw`  in  1  transfer direction: 1 = read, 0 = write.
- `req_dev`  in  7  7-bit device address.
- `req_reg`  in  8  register address.
- `req_wdata`  in  8  write data (ignored for reads).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; 0x00 for writes and for errored reads.
- `rsp_err`  out  1  1 = a WR byte was NACKed.
- `rsp_err_step`  out  3  step index of the NACKed byte (0 when `rsp_err`=0).
- `m_cmd`  out  3  command to the controller.
- `m_din`  out  8  data byte to the controller.
- `m_wr`  out  1  command strobe to the controller.
- `m_ready`  in  1  controller ready.
- `m_done_tick`  in  1  controller byte-complete pulse.
- `m_ack`  in  1  controller ack bit (0 = ACK).
- `m_dout`  in  8  controller received byte.

## Operation
- States: IDLE, ISSUE, GAP, WAIT, RESP. A 3-bit `step` register indexes the command list. Latched request fields: `rw`, `dev`, `reg`, `wdata`.
- Write list:
  - 0: START
  - 1: WR {dev,0}
  - 2: WR reg
  - 3: WR wdata
  - 4: STOP
- Read list:
  - 0: START
  - 1: WR {dev,0}
  - 2: WR reg
  - 3: RESTART
  - 4: WR {dev,1}
  - 5: RD with `m_din`=8'h01 (master NACKs the single read byte)
  - 6: STOP
- `m_din` = 8'h00 for START, RESTART and STOP.
- IDLE:
  - `req_ready` = `m_ready`.
  - On accept: latch fields, set step=0, clear the error and capture registers, go to ISSUE.
- ISSUE: `m_wr`=1 for exactly this cycle; `m_cmd`/`m_din` decoded from step and the latched fields. Next state: GAP.
- GAP: one cycle with `m_ready` ignored, which covers the controller's one-cycle ready deassertion. Next state: WAIT.
- WAIT: clear the byte-done flag on entry.
  - On `m_done_tick`, set byte-done.
  - WR step: if `m_ack`=1, set err and record the step.
  - RD step: capture `m_dout`.
- Leaving WAIT: requires `m_ready`=1, plus byte-done for WR/RD steps.
  - Current step is STOP → RESP.
  - Else if err is set → jump to the STOP step (4 for write, 6 for read) → ISSUE.
  - Otherwise step+1 → ISSUE.
- RESP: `rsp_valid`=1 for one cycle, → IDLE.
- `rsp_rdata`, `rsp_err` and `rsp_err_step` are held stable from RESP until the next accept.
- `m_cmd`, `m_din` and `m_wr` depend only on registers. There is no combinational path from any `m_*` input.
- `req_valid` outside IDLE is ignored and never queued.

## Timing
- Reset values: `req_ready`=0 during the reset cycle. `m_wr`=0, `m_cmd`=3'b000, `m_din`=8'h00, `rsp_valid`=0, `rsp_rdata`=8'h00, `rsp_err`=0, `rsp_err_step`=0. State = IDLE, step = 0.
- Accept at edge t → `m_wr`=1 during cycle t+1 (START).
- Minimum spacing between consecutive `m_wr` pulses is 3 cycles (ISSUE, GAP, WAIT≥1).
- `rsp_valid` is asserted the cycle after the STOP completes (`m_ready`=1 in WAIT). The earliest next accept is 2 cycles after that.
- `m_done_tick` and `m_ack` are sampled in the same cycle. A done_tick arriving in GAP is also recorded.
- Reset mid-transaction: the block returns to IDLE next cycle and no STOP is issued. The controller shares `rst` and is reset together.

## Test plan
- Write dev=0x50 reg=0x10 data=0xA5, controller ACKs all bytes → commands START, WR 0xA0, WR 0x10, WR 0xA5, STOP in that order; one `rsp_valid` with `rsp_err`=0 and `rsp_rdata`=0x00.
- Read dev=0x50 reg=0x22, slave returns 0x3C → commands START, WR 0xA0, WR 0x22, RESTART, WR 0xA1, RD (din=0x01), STOP; `rsp_rdata`=0x3C, `rsp_err`=0.
- Read dev=0x68 with address NACK at step 1 (`m_ack`=1) → next command is STOP; `rsp_err`=1, `rsp_err_step`=1, `rsp_rdata`=0x00.
- Write with data-byte NACK (step 3) → STOP issued; `rsp_err_step`=3; no further WR commands.
- `req_valid` held high throughout a transaction, plus `m_ready` low in IDLE → exactly one accept per transaction; no accept while `m_ready`=0; no two `m_wr` pulses closer than 3 cycles.
- `rst` asserted during the step-2 WAIT → next cycle `m_wr`=0, state IDLE, `rsp_valid` never pulses; a new request afterwards completes normally.
